// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchroniser, tick counter and bit-centre strobe; sample_bit is a 3-tap majority when
// UART_RX_MAJORITY_EN is defined, else the single synchronised sample. No backpressure.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic cnt_clr,
  input  logic half_bit,
  output logic rx_s,
  output logic sample_stb,
  output logic sample_bit
);

  localparam int CNT_W = $clog2(OVERSAMPLE);

  logic             meta;
  logic [CNT_W-1:0] cnt;
  logic             at_point;

`ifdef UART_RX_MAJORITY_EN
  // hist[0] doubles as the second synchroniser stage; hist[2:1] are the two prior ticks.
  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b1;
      hist <= 3'b111;
    end else begin
      meta <= rx;
      hist <= {hist[1:0], meta};
    end
  end

  assign rx_s       = hist[0];
  assign sample_bit = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
  logic sync2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta  <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      meta  <= rx;
      sync2 <= meta;
    end
  end

  assign rx_s       = sync2;
  assign sample_bit = sync2;
`endif

  assign at_point   = half_bit ? (cnt == CNT_W'(OVERSAMPLE/2 - 1))
                               : (cnt == CNT_W'(OVERSAMPLE - 1));
  assign sample_stb = !cnt_clr && at_point;

  // Restarting at each strobe re-aligns the count after the half-bit start sample.
  always_ff @(posedge clk) begin
    if (!reset || cnt_clr || sample_stb) cnt <= '0;
    else                                 cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (data width, parity, stop bits; UART_RX_MAJORITY_EN adds majority
// sampling). Word valid 1 cycle after last stop sample; held while !ready, later frames dropped (overrun).
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic                 uart_samplig_clk,
  input  logic                 reset,
  input  logic                 RsRx,
  output logic                 valid,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] received_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int IDX_W = $clog2(DATA_BITS);

  uart_state_t          state, state_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic                 stop_idx, stop_idx_nxt;
  logic [DATA_BITS-1:0] payload, payload_nxt;
  logic                 perr, perr_nxt, ferr, ferr_nxt;
  logic                 done;
  logic                 valid_nxt, parity_err_nxt, frame_err_nxt, overrun_nxt;
  logic [DATA_BITS-1:0] received_data_nxt;
  logic                 rx_s, stb, sbit;

  uart_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (uart_samplig_clk),
    .reset      (reset),
    .rx         (RsRx),
    .cnt_clr    (state == IDLE),
    .half_bit   (state == START),
    .rx_s       (rx_s),
    .sample_stb (stb),
    .sample_bit (sbit)
  );

  always_comb begin
    state_nxt    = state;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    payload_nxt  = payload;
    perr_nxt     = perr;
    ferr_nxt     = ferr;
    done         = 1'b0;
    case (state)
      IDLE: if (!rx_s) state_nxt = START;
      START: if (stb) begin
        if (sbit) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          perr_nxt    = 1'b0;
          ferr_nxt    = 1'b0;
        end
      end
      DATA: if (stb) begin
        payload_nxt = {sbit, payload[DATA_BITS-1:1]};
        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
          state_nxt    = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          stop_idx_nxt = 1'b0;
        end else begin
          bit_idx_nxt = bit_idx + 1'b1;
        end
      end
      PARITY: if (stb) begin
        perr_nxt  = sbit ^ (^payload) ^ (PARITY_MODE == PARITY_ODD);
        state_nxt = STOP;
      end
      STOP: if (stb) begin
        ferr_nxt = ferr | !sbit;
        if (stop_idx == 1'(STOP_BITS - 1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          stop_idx_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_nxt         = valid;
    received_data_nxt = received_data;
    parity_err_nxt    = parity_err;
    frame_err_nxt     = frame_err;
    overrun_nxt       = overrun;
    if (done && (!valid || ready)) begin
      valid_nxt         = 1'b1;
      received_data_nxt = payload;
      parity_err_nxt    = perr;
      frame_err_nxt     = ferr_nxt;
      if (valid) overrun_nxt = 1'b0;
    end else if (done) begin
      overrun_nxt = 1'b1;
    end else if (valid && ready) begin
      valid_nxt   = 1'b0;
      overrun_nxt = 1'b0;
    end
  end

  always_ff @(posedge uart_samplig_clk) begin
    if (!reset) begin
      state         <= IDLE;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
      payload       <= '0;
      perr          <= 1'b0;
      ferr          <= 1'b0;
      valid         <= 1'b0;
      received_data <= '0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_idx       <= bit_idx_nxt;
      stop_idx      <= stop_idx_nxt;
      payload       <= payload_nxt;
      perr          <= perr_nxt;
      ferr          <= ferr_nxt;
      valid         <= valid_nxt;
      received_data <= received_data_nxt;
      parity_err    <= parity_err_nxt;
      frame_err     <= frame_err_nxt;
      overrun       <= overrun_nxt;
    end
  end

endmodule
